// File: rtl/bnn_pool_bin.sv
// Max-pools three signed conv channels over POOL results, binarizes each pooled value
// against a per-channel threshold and packs the bits into one feature vector per sequence.
module bnn_pool_bin #(
    parameter int                 N_CONV = 36,
    parameter int                 POOL   = 2,
    parameter logic signed [31:0] TH1    = 32'sd0,
    parameter logic signed [31:0] TH2    = 32'sd0,
    parameter logic signed [31:0] TH3    = 32'sd0,
    localparam int                N_OUT  = N_CONV / POOL,
    localparam int                FW     = 3 * N_OUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          conv_vld,
    input  logic [31:0]   conv_in [1:3],
    output logic          bin_vld,
    output logic [2:0]    bin_out,
    output logic [FW-1:0] feat_out,
    output logic          feat_vld,
    output logic          busy,
    output logic          done
);

    localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_pool_cnt;
    logic [OW-1:0]      r_out_cnt;
    logic signed [31:0] r_max [1:3];
    logic               r_bin_vld;
    logic [2:0]         r_bin_out;
    logic [FW-1:0]      r_feat;
    logic               r_feat_vld;
    logic               r_busy;
    logic               r_done;

    logic signed [31:0] w_cand [1:3];
    logic [2:0]         w_bits;
    logic [FW-1:0]      w_feat_next;
    logic               w_accept;
    logic               w_win_end;
    logic               w_last;

    // The incoming value replaces the stored maximum only when strictly larger.
    function automatic logic signed [31:0] max_keep_first(
        input logic signed [31:0] kept,
        input logic signed [31:0] incoming
    );
        logic signed [31:0] res;
        if (incoming > kept) begin
            res = incoming;
        end else begin
            res = kept;
        end
        return res;
    endfunction

    function automatic logic at_or_above(
        input logic signed [31:0] value,
        input logic signed [31:0] thresh
    );
        return (value >= thresh) ? 1'b1 : 1'b0;
    endfunction

    // Candidate maxima, binarized bits and acceptance/window qualifiers for this cycle.
    always_comb begin
        for (int c = 1; c <= 3; c++) begin
            if (r_pool_cnt == {PW{1'b0}}) begin
                w_cand[c] = $signed(conv_in[c]);
            end else begin
                w_cand[c] = max_keep_first(r_max[c], $signed(conv_in[c]));
            end
        end
        w_bits[0]   = at_or_above(w_cand[1], TH1);
        w_bits[1]   = at_or_above(w_cand[2], TH2);
        w_bits[2]   = at_or_above(w_cand[3], TH3);
        w_feat_next = r_feat << 32'd3;
        w_feat_next[2:0] = w_bits;
        w_accept  = (r_state == S_RUN) && conv_vld && !start;
        w_win_end = w_accept && (r_pool_cnt == PW'(POOL - 1));
        w_last    = w_win_end && (r_out_cnt == OW'(N_OUT - 1));
    end

    // Sequence FSM with pooling state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pool_cnt <= {PW{1'b0}};
            r_out_cnt  <= {OW{1'b0}};
            for (int c = 1; c <= 3; c++) begin
                r_max[c] <= 32'sd0;
            end
            r_bin_vld  <= 1'b0;
            r_bin_out  <= 3'b000;
            r_feat     <= {FW{1'b0}};
            r_feat_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_bin_vld  <= 1'b0;
            r_feat_vld <= 1'b0;
            if (start) begin
                // bin_out deliberately holds its last value across a restart.
                r_state    <= S_RUN;
                r_pool_cnt <= {PW{1'b0}};
                r_out_cnt  <= {OW{1'b0}};
                for (int c = 1; c <= 3; c++) begin
                    r_max[c] <= 32'sd0;
                end
                r_feat     <= {FW{1'b0}};
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else if (w_accept) begin
                for (int c = 1; c <= 3; c++) begin
                    r_max[c] <= w_cand[c];
                end
                if (w_win_end) begin
                    r_pool_cnt <= {PW{1'b0}};
                    r_bin_out  <= w_bits;
                    r_bin_vld  <= 1'b1;
                    r_feat     <= w_feat_next;
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_out_cnt  <= {OW{1'b0}};
                        r_feat_vld <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_out_cnt  <= r_out_cnt + OW'(1);
                    end
                end else begin
                    r_pool_cnt <= r_pool_cnt + PW'(1);
                end
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign bin_vld  = r_bin_vld;
    assign bin_out  = r_bin_out;
    assign feat_out = r_feat;
    assign feat_vld = r_feat_vld;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_bnn_pool_bin.sv
// Randomized scoreboard bench for bnn_pool_bin: two instances (default and boundary
// thresholds) share one stimulus stream and one window-level reference model.
module tb_bnn_pool_bin;

    localparam int N_CONV = 36;
    localparam int POOL   = 2;
    localparam int N_OUT  = N_CONV / POOL;
    localparam int FW     = 3 * N_OUT;
    localparam int A_TH1 = 0,   A_TH2 = 0,  A_TH3 = 0;
    localparam int B_TH1 = 100, B_TH2 = -1, B_TH3 = 32'h7FFFFFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          conv_vld;
    logic [31:0]   conv_in [1:3];
    logic          a_bin_vld, b_bin_vld, a_feat_vld, b_feat_vld;
    logic [2:0]    a_bin_out, b_bin_out;
    logic [FW-1:0] a_feat_out, b_feat_out;
    logic          a_busy, b_busy, a_done, b_done;

    bnn_pool_bin #(.N_CONV(N_CONV), .POOL(POOL), .TH1(A_TH1), .TH2(A_TH2), .TH3(A_TH3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .conv_vld(conv_vld), .conv_in(conv_in),
        .bin_vld(a_bin_vld), .bin_out(a_bin_out), .feat_out(a_feat_out),
        .feat_vld(a_feat_vld), .busy(a_busy), .done(a_done));

    bnn_pool_bin #(.N_CONV(N_CONV), .POOL(POOL), .TH1(B_TH1), .TH2(B_TH2), .TH3(B_TH3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .conv_vld(conv_vld), .conv_in(conv_in),
        .bin_vld(b_bin_vld), .bin_out(b_bin_out), .feat_out(b_feat_out),
        .feat_vld(b_feat_vld), .busy(b_busy), .done(b_done));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the open window, pooled outputs so far, sequence status.
    bit            m_run, m_done;
    int            w1[$], w2[$], w3[$];
    logic [2:0]    outs_a[$], outs_b[$];
    logic [2:0]    m_bin_a, m_bin_b;
    logic [2:0]    exp_bin_a[$], exp_bin_b[$];
    logic [FW-1:0] exp_feat_a[$], exp_feat_b[$];
    int            n_feat_exp, n_feat_a, n_feat_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wmax(input int ch);
        int m = 0;
        case (ch)
            1: begin m = w1[0]; foreach (w1[i]) if (w1[i] > m) m = w1[i]; end
            2: begin m = w2[0]; foreach (w2[i]) if (w2[i] > m) m = w2[i]; end
            3: begin m = w3[0]; foreach (w3[i]) if (w3[i] > m) m = w3[i]; end
            default: m = 0;
        endcase
        return m;
    endfunction

    // Output j of n ends up (n-1-j) triplets above the bottom of the vector.
    function automatic logic [FW-1:0] pack(input bit sel);
        logic [FW-1:0] v = '0;
        int n = sel ? outs_b.size() : outs_a.size();
        for (int j = 0; j < n; j++) v[3*(n-1-j) +: 3] = sel ? outs_b[j] : outs_a[j];
        return v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_bin_a = 3'b000; m_bin_b = 3'b000;
        w1.delete(); w2.delete(); w3.delete();
        outs_a.delete(); outs_b.delete();
        exp_bin_a.delete(); exp_bin_b.delete(); exp_feat_a.delete(); exp_feat_b.delete();
    endtask

    task automatic model_edge(input bit vld, input int a, input int b, input int c, input bit st);
        int mx1, mx2, mx3;
        logic [2:0] ba, bb;
        if (st) begin
            m_run = 1; m_done = 0;
            w1.delete(); w2.delete(); w3.delete();
            outs_a.delete(); outs_b.delete();
        end else if (vld && m_run) begin
            w1.push_back(a); w2.push_back(b); w3.push_back(c);
            if (w1.size() == POOL) begin
                mx1 = wmax(1); mx2 = wmax(2); mx3 = wmax(3);
                ba = {mx3 >= A_TH3, mx2 >= A_TH2, mx1 >= A_TH1};
                bb = {mx3 >= B_TH3, mx2 >= B_TH2, mx1 >= B_TH1};
                m_bin_a = ba; m_bin_b = bb;
                exp_bin_a.push_back(ba); exp_bin_b.push_back(bb);
                outs_a.push_back(ba); outs_b.push_back(bb);
                w1.delete(); w2.delete(); w3.delete();
                if (outs_a.size() == N_OUT) begin
                    m_run = 0; m_done = 1; n_feat_exp++;
                    exp_feat_a.push_back(pack(1'b0));
                    exp_feat_b.push_back(pack(1'b1));
                end
            end
        end
    endtask

    task automatic step(input bit vld, input int a, input int b, input int c, input bit st);
        conv_vld = vld; start = st;
        conv_in[1] = a; conv_in[2] = b; conv_in[3] = c;
        @(posedge clk);
        if (rst_n) model_edge(vld, a, b, c, st);
        #1;
    endtask

    function automatic int rv();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    // Monitor: pops expected pulses when the DUT presents them, checks held outputs each cycle.
    always @(negedge clk) begin
        logic [2:0] eb;
        logic [FW-1:0] ef;
        check("a_bin_vld", a_bin_vld, exp_bin_a.size() != 0);
        if (exp_bin_a.size() != 0) begin
            eb = exp_bin_a.pop_front();
            if (a_bin_vld) check("a_bin_pulse", a_bin_out, eb);
        end
        check("b_bin_vld", b_bin_vld, exp_bin_b.size() != 0);
        if (exp_bin_b.size() != 0) begin
            eb = exp_bin_b.pop_front();
            if (b_bin_vld) check("b_bin_pulse", b_bin_out, eb);
        end
        check("a_feat_vld", a_feat_vld, exp_feat_a.size() != 0);
        if (exp_feat_a.size() != 0) begin
            ef = exp_feat_a.pop_front();
            if (a_feat_vld) check("a_feat_pulse", a_feat_out, ef);
        end
        check("b_feat_vld", b_feat_vld, exp_feat_b.size() != 0);
        if (exp_feat_b.size() != 0) begin
            ef = exp_feat_b.pop_front();
            if (b_feat_vld) check("b_feat_pulse", b_feat_out, ef);
        end
        if (a_feat_vld) n_feat_a++;
        if (b_feat_vld) n_feat_b++;
        check("a_bin_out", a_bin_out, m_bin_a);
        check("b_bin_out", b_bin_out, m_bin_b);
        check("a_feat_out", a_feat_out, pack(1'b0));
        check("b_feat_out", b_feat_out, pack(1'b1));
        check("a_busy", a_busy, m_run);
        check("b_busy", b_busy, m_run);
        check("a_done", a_done, m_done);
        check("b_done", b_done, m_done);
    end

    initial begin
        logic [FW-1:0] snap;
        n_feat_exp = 0; n_feat_a = 0; n_feat_b = 0;
        model_reset();
        rst_n = 1'b0; start = 1'b0; conv_vld = 1'b0;
        conv_in[1] = 32'd0; conv_in[2] = 32'd0; conv_in[3] = 32'd0;
        #22 rst_n = 1'b1;

        // Idle: strobes without start are ignored.
        for (int i = 0; i < 5; i++) step(1'b1, rv(), rv(), rv(), 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);

        // Basic pooling pair.
        step(1'b0, 0, 0, 0, 1'b1);
        check("start_busy", a_busy, 1'b1);
        step(1'b1, -5, -1, 0, 1'b0);
        step(1'b1, 3, -2, -7, 1'b0);
        check("basic_vld", a_bin_vld, 1'b1);
        check("basic_bin", a_bin_out, 3'b101);
        step(1'b0, 0, 0, 0, 1'b0);

        // Full sequence, back-to-back, then an extra strobe in DONE.
        step(1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < N_CONV; i++) step(1'b1, 1, -1, 1, 1'b0);
        check("full_feat_vld", a_feat_vld, 1'b1);
        check("full_feat", a_feat_out, {18{3'b101}});
        check("full_done", a_done, 1'b1);
        check("full_busy", a_busy, 1'b0);
        snap = a_feat_out;
        step(1'b1, -9, 9, -9, 1'b0);
        check("s37_feat_vld", a_feat_vld, 1'b0);
        check("s37_feat_stable", a_feat_out, snap);
        step(1'b0, 0, 0, 0, 1'b0);

        // Threshold boundaries on the second instance.
        step(1'b0, 0, 0, 0, 1'b1);
        step(1'b1, 100, int'(32'h80000000), rv(), 1'b0);
        step(1'b1, 99, -1, rv(), 1'b0);
        check("th_eq_bit0", b_bin_out[0], 1'b1);
        check("th_neg_bit1", b_bin_out[1], 1'b1);
        step(1'b1, 99, -2, rv(), 1'b0);
        step(1'b1, 99, int'(32'h80000000), rv(), 1'b0);
        check("th_below_bit0", b_bin_out[0], 1'b0);
        check("th_below_bit1", b_bin_out[1], 1'b0);

        // Restart mid-sequence; start wins over a simultaneous strobe.
        step(1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, rv(), rv(), rv(), 1'b0);
        step(1'b1, rv(), rv(), rv(), 1'b1);
        check("restart_feat_clr", a_feat_out, '0);
        for (int i = 0; i < N_CONV; i++) step(1'b1, rv(), rv(), rv(), 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);

        // Asynchronous reset between edges, mid-run.
        step(1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b1, rv(), rv(), rv(), 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_busy", a_busy, 1'b0);
        check("rst_bin_out", a_bin_out, 3'b000);
        check("rst_feat_out", b_feat_out, '0);
        check("rst_bin_vld", b_bin_vld, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rv(), rv(), rv(), 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, rv(), rv(), rv(), 1'b0);

        // Random full sequence with gaps.
        step(1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < N_CONV; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, rv(), rv(), rv(), 1'b0);
            step(1'b1, rv(), rv(), rv(), 1'b0);
        end
        step(1'b1, rv(), rv(), rv(), 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);

        check("feat_count_a", n_feat_a, n_feat_exp);
        check("feat_count_b", n_feat_b, n_feat_exp);
        check("bin_queue_empty", exp_bin_a.size() + exp_bin_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
